// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo.
// master: the producer/consumer side. It drives the requests and write data,
//         and observes the read data and the status flags.
// slave : the FIFO itself.
// Signals
//   winc, wdata       write request and write data
//   rinc              read request
//   err_clr           clears the sticky overflow/underflow flags
//   rdata, rvalid     registered read data, plus a one-cycle valid pulse
//   wfull, rempty     occupancy == DEPTH / occupancy == 0
//   walmost_full      occupancy >= AF_TH
//   ralmost_empty     occupancy <= AE_TH
//   count             current occupancy, 0..DEPTH
//   overflow          sticky flag: a write was attempted while full
//   underflow         sticky flag: a read was attempted while empty
interface sync_fifo_if #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 444
);
  localparam int CNTSIZE = $clog2(DEPTH + 1);

  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic                err_clr;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                wfull;
  logic                rempty;
  logic                walmost_full;
  logic                ralmost_empty;
  logic [CNTSIZE-1:0]  count;
  logic                overflow;
  logic                underflow;

  modport master (
    output winc, wdata, rinc, err_clr,
    input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, err_clr,
    output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port (1-cycle latency).
// DEPTH may be any value >= 2. Pointers wrap by explicit compare.
// All status flags are decoded from the registered occupancy count.
// This means no request input has a combinational path to any output.
// Ports
//   wclk   clock; all logic runs on its rising edge
//   wrst   synchronous active-high reset
//          clears pointers, count, rdata, rvalid and the error flags
//          memory contents are kept
//   bus    sync_fifo_if slave modport (requests, data, status)
module sync_fifo #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 444,
  parameter int AF_TH    = 440,
  parameter int AE_TH    = 4
) (
  input  logic        wclk,
  input  logic        wrst,
  sync_fifo_if.slave  bus
);
  localparam int ADDRSIZE = $clog2(DEPTH);
  localparam int CNTSIZE  = $clog2(DEPTH + 1);

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [ADDRSIZE-1:0] r_waddr;
  logic [ADDRSIZE-1:0] r_raddr;
  logic [CNTSIZE-1:0]  r_count;
  logic [DATASIZE-1:0] r_rdata;
  logic                r_rvalid;
  logic                r_overflow;
  logic                r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Advance a pointer by one entry.
  // The pointer wraps from DEPTH-1 to 0 because DEPTH need not be a power of two.
  function automatic logic [ADDRSIZE-1:0] ptr_inc(input logic [ADDRSIZE-1:0] p);
    logic [ADDRSIZE-1:0] n;
    if (p == ADDRSIZE'(DEPTH - 1)) n = '0;
    else                           n = p + 1'b1;
    return n;
  endfunction

  assign w_full   = (r_count == CNTSIZE'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Acceptance looks only at the registered flags.
  // At full, a simultaneous read is still accepted, but the write is not.
  // At empty, the write is accepted, but the read is not.
  assign w_wr_acc = bus.winc && !w_full;
  assign w_rd_acc = bus.rinc && !w_empty;

  // Storage: no reset, and writes are blocked while wrst is high
  always_ff @(posedge wclk) begin
    if (!wrst && w_wr_acc) r_mem[r_waddr] <= bus.wdata;
  end

  // Pointers, occupancy and the registered read port
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_wr_acc) r_waddr <= ptr_inc(r_waddr);
      if (w_rd_acc) begin
        r_raddr <= ptr_inc(r_raddr);
        r_rdata <= r_mem[r_raddr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNTSIZE'(1);
        2'b01:   r_count <= r_count - CNTSIZE'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags
  // If a new error arrives in the same cycle as err_clr, the error wins.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.winc && w_full) r_overflow <= 1'b1;
      else if (bus.err_clr)   r_overflow <= 1'b0;
      if (bus.rinc && w_empty) r_underflow <= 1'b1;
      else if (bus.err_clr)    r_underflow <= 1'b0;
    end
  end

  assign bus.rdata         = r_rdata;
  assign bus.rvalid        = r_rvalid;
  assign bus.count         = r_count;
  assign bus.wfull         = w_full;
  assign bus.rempty        = w_empty;
  assign bus.walmost_full  = (r_count >= CNTSIZE'(AF_TH));
  assign bus.ralmost_empty = (r_count <= CNTSIZE'(AE_TH));
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;
  localparam int DW  = 8;
  localparam int DEP = 444;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   wseq;
  int   rseq;

  sync_fifo_if #(.DATASIZE(DW), .DEPTH(DEP)) bus ();

  sync_fifo #(.DATASIZE(DW), .DEPTH(DEP), .AF_TH(440), .AE_TH(4)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with the given requests, then sample 1 time unit after the edge
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic e);
    bus.winc = w; bus.wdata = d; bus.rinc = r; bus.err_clr = e;
    @(posedge wclk); #1;
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.err_clr = 1'b0;
  endtask

  initial begin
    bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0; bus.err_clr = 1'b0;
    wrst = 1'b1;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    wrst = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_rempty", bus.rempty, 1);
    chk("rst_ralmost_empty", bus.ralmost_empty, 1);
    chk("rst_wfull", bus.wfull, 0);
    chk("rst_walmost_full", bus.walmost_full, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_underflow", bus.underflow, 0);

    // 1. fill to full, then drain in order
    for (int i = 0; i < DEP; i++) begin
      cyc(1, i[7:0], 0, 0);
      chk("fill_count", bus.count, i + 1);
      chk("fill_walmost_full", bus.walmost_full, (i + 1 >= 440) ? 1 : 0);
      chk("fill_ralmost_empty", bus.ralmost_empty, (i + 1 <= 4) ? 1 : 0);
    end
    chk("fill_wfull", bus.wfull, 1);
    chk("fill_overflow", bus.overflow, 0);
    for (int i = 0; i < DEP; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("drain_rvalid", bus.rvalid, 1);
      chk("drain_rdata", bus.rdata, i & 255);
    end
    chk("drain_rempty", bus.rempty, 1);
    chk("drain_underflow", bus.underflow, 0);
    cyc(0, 8'h00, 0, 0);
    chk("idle_rvalid", bus.rvalid, 0);
    chk("idle_rdata_hold", bus.rdata, (DEP - 1) & 255);

    // 2. wrap across index DEPTH-1 -> 0
    for (int i = 0; i < 300; i++) cyc(1, 8'(i * 7 + 3), 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("wrap1_rdata", bus.rdata, (i * 7 + 3) & 255);
    end
    for (int i = 0; i < 300; i++) cyc(1, 8'(i * 11 + 1), 0, 0);
    chk("wrap2_count", bus.count, 300);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("wrap2_rdata", bus.rdata, (i * 11 + 1) & 255);
    end
    chk("wrap_rempty", bus.rempty, 1);

    // 3. simultaneous write and read at full
    for (int i = 0; i < DEP; i++) cyc(1, 8'(i) ^ 8'h5A, 0, 0);
    chk("full_wfull", bus.wfull, 1);
    cyc(1, 8'hEE, 1, 0);
    chk("full_both_count", bus.count, DEP - 1);
    chk("full_both_overflow", bus.overflow, 1);
    chk("full_both_rvalid", bus.rvalid, 1);
    chk("full_both_rdata", bus.rdata, 8'h5A);
    chk("full_both_wfull", bus.wfull, 0);
    cyc(0, 8'h00, 0, 1);
    chk("errclr_overflow", bus.overflow, 0);
    chk("errclr_count", bus.count, DEP - 1);
    for (int i = 1; i < DEP; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("full_drain_rdata", bus.rdata, (i ^ 'h5A) & 255);
    end
    chk("full_drain_rempty", bus.rempty, 1);

    // 4. simultaneous write and read at empty
    cyc(1, 8'hA5, 1, 0);
    chk("empty_both_count", bus.count, 1);
    chk("empty_both_underflow", bus.underflow, 1);
    chk("empty_both_rvalid", bus.rvalid, 0);
    cyc(0, 8'h00, 1, 0);
    chk("empty_next_rdata", bus.rdata, 8'hA5);
    chk("empty_next_rvalid", bus.rvalid, 1);
    chk("empty_next_count", bus.count, 0);
    cyc(0, 8'h00, 1, 1);
    chk("errclr_vs_new_underflow", bus.underflow, 1);
    chk("rejected_read_rvalid", bus.rvalid, 0);
    cyc(0, 8'h00, 0, 1);
    chk("errclr_underflow", bus.underflow, 0);

    // 5. steady stream at count 100
    wseq = 0; rseq = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1, wseq[7:0], 0, 0);
      wseq++;
    end
    for (int i = 0; i < 1000; i++) begin
      cyc(1, wseq[7:0], 1, 0);
      wseq++;
      chk("stream_count", bus.count, 100);
      chk("stream_rdata", bus.rdata, rseq & 255);
      rseq++;
    end
    chk("stream_overflow", bus.overflow, 0);
    chk("stream_underflow", bus.underflow, 0);
    chk("stream_wfull", bus.wfull, 0);
    chk("stream_rempty", bus.rempty, 0);
    chk("stream_walmost_full", bus.walmost_full, 0);
    chk("stream_ralmost_empty", bus.ralmost_empty, 0);

    // 6. reset mid-stream at count 200; reset dominates requests
    for (int i = 0; i < 100; i++) begin
      cyc(1, wseq[7:0], 0, 0);
      wseq++;
    end
    chk("pre_rst_count", bus.count, 200);
    wrst = 1'b1;
    cyc(1, 8'h77, 1, 1);
    wrst = 1'b0;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_rempty", bus.rempty, 1);
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    chk("mid_rst_overflow", bus.overflow, 0);
    chk("mid_rst_underflow", bus.underflow, 0);
    cyc(1, 8'h3C, 0, 0);
    chk("post_rst_count", bus.count, 1);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_rdata", bus.rdata, 8'h3C);
    chk("post_rst_rempty", bus.rempty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
